// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter.
// State encoding, requester count and hold-limit default.
package mux_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned MAX_HOLD_DEF = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_rr_priority_pick.sv
// Rotating-priority picker: first eligible requester at or after ptr.
// Eligible means req and mask both set; the search wraps 3 -> 0.
module rr_priority_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic       found,
    output logic [1:0] idx
);

    logic [3:0] elig;
    logic [1:0] cand;

    assign elig = req & mask;

    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with a bounded hold time.
// The mux output is registered one cycle behind the grant.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       y,
    output logic       y_vld
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic       state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       y_q, yvld_q;

    logic [1:0] pick_ptr;
    logic [3:0] pick_mask;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       release_w, expire_w;

    // While busy, search after the owner and exclude it from the pick.
    assign pick_ptr  = (state_q == ST_BUSY) ? sel_q + 2'd1 : ptr_q;
    assign pick_mask = (state_q == ST_BUSY) ? ~gnt_q : 4'hF;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign release_w = ~req[sel_q];
    assign expire_w  = hold_q >= HOLD_MAX;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    gnt_d   = 4'd1 << pick_idx;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx + 2'd1;
                    hold_d  = 4'd1;
                end
            end
            default: begin
                if (release_w || expire_w) begin
                    if (pick_found) begin
                        gnt_d  = 4'd1 << pick_idx;
                        sel_d  = pick_idx;
                        ptr_d  = pick_idx + 2'd1;
                        hold_d = 4'd1;
                    end else if (release_w) begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'd0;
                        sel_d   = 2'd0;
                        ptr_d   = sel_q + 2'd1;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d = 4'd1;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            y_q     <= 1'b0;
            yvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            y_q     <= din[sel_q];
            yvld_q  <= (state_q == ST_BUSY);
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign busy  = (state_q == ST_BUSY);
    assign y     = y_q;
    assign y_vld = yvld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       y_vld;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .y     (y),
        .y_vld (y_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg,
                           input logic [1:0] es, input logic eb);
        chk({tag, ".gnt"}, 8'(gnt), 8'(eg));
        chk({tag, ".sel"}, 8'(sel), 8'(es));
        chk({tag, ".busy"}, 8'(busy), 8'(eb));
    endtask

    initial begin
        logic [3:0] dpat;
        int own;
        rst = 1'b1;
        req = 4'b1111;
        din = 4'b0000;

        // Reset held two cycles with all requesting
        tick();
        chk_out("rst1", 4'b0000, 2'd0, 1'b0);
        chk("rst1.yvld", 8'(y_vld), 8'd0);
        tick();
        chk_out("rst2", 4'b0000, 2'd0, 1'b0);
        chk("rst2.yvld", 8'(y_vld), 8'd0);
        chk("rst2.y", 8'(y), 8'd0);

        rst = 1'b0;
        dpat = 4'b1010;
        din = dpat;
        tick();
        chk_out("rel", 4'b0001, 2'd0, 1'b1);
        chk("rel.yvld", 8'(y_vld), 8'd0);

        // Fairness: 4 cycles per owner, 0,1,2,3,0
        for (int k = 1; k <= 16; k++) begin
            tick();
            own = (k / 4) % 4;
            chk($sformatf("fair%0d", k), 8'(gnt), 8'(4'd1 << own));
            chk($sformatf("fair%0d.y", k), 8'(y),
                8'(dpat[((k - 1) / 4) % 4]));
            chk($sformatf("fair%0d.yvld", k), 8'(y_vld), 8'd1);
        end

        // Single requester 2: owner 0 releases, then 10 steady cycles
        req = 4'b0100;
        tick();
        chk_out("single0", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 0) ? 4'b0100 : 4'b1011;
            tick();
            chk_out($sformatf("single%0d", i + 1), 4'b0100, 2'd2, 1'b1);
            chk($sformatf("single%0d.y", i + 1), 8'(y),
                8'((i % 2 == 0) ? 1 : 0));
        end

        // Wrap-around from ptr 3 to requester 0, then idle
        req = 4'b0001;
        din = 4'b0001;
        tick();
        chk_out("wrap", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk_out("idle", 4'b0000, 2'd0, 1'b0);
        chk("idle.yvld", 8'(y_vld), 8'd1);
        chk("idle.y", 8'(y), 8'd1);
        tick();
        chk_out("idle2", 4'b0000, 2'd0, 1'b0);
        chk("idle2.yvld", 8'(y_vld), 8'd0);

        // Early release: owner 1 drops with req[3]=1, req[2]=0
        req = 4'b0010;
        tick();
        chk_out("own1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        tick();
        chk_out("early3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0010;
        tick();
        chk_out("own1b", 4'b0010, 2'd1, 1'b1);
        req = 4'b1100;
        tick();
        chk_out("early2", 4'b0100, 2'd2, 1'b1);

        // Mid-grant reset during owner 2
        req = 4'b0110;
        rst = 1'b1;
        tick();
        chk_out("mrst", 4'b0000, 2'd0, 1'b0);
        chk("mrst.y", 8'(y), 8'd0);
        chk("mrst.yvld", 8'(y_vld), 8'd0);
        rst = 1'b0;
        tick();
        chk_out("post", 4'b0010, 2'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
